// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace checker.
// Record layout, kind codes, FSM states and the match rule.
package commit_trace_pkg;

  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_ST   = 3'd3,
    KIND_HALT = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_e;

  typedef struct packed {
    kind_e       kind;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] value;
    logic [15:0] addr;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  // Fields outside a kind's rule are don't-care.
  function automatic logic rec_match(rec_t got, rec_t want);
    logic m;
    m = (got.kind == want.kind) && (got.pc == want.pc);
    case (want.kind)
      KIND_REG: m = m && (got.rd == want.rd)
                      && (got.value == want.value);
      KIND_LD:  m = m && (got.rd == want.rd)
                      && (got.value == want.value)
                      && (got.addr == want.addr);
      KIND_ST:  m = m && (got.addr == want.addr)
                      && (got.value == want.value);
      default:  m = m;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/commit_trace_checker_fifo.sv
// Synchronous commit buffer.
// Pointers carry an extra wrap bit to tell full from empty.
module commit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 55
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  // Status, accepted operations and pointer advance.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) &&
              (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
    dout    = mem[rd_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; a full-and-popping write reuses the slot being read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/commit_trace_checker.sv
// Compares CPU commits against a golden trace stream.
// Reports pass/fail, mismatch count and first-failure info.
module commit_trace_checker
  import commit_trace_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] c_pc,
  input  logic        c_regwrite,
  input  logic [3:0]  c_reg,
  input  logic [15:0] c_wdata,
  input  logic        c_memread,
  input  logic        c_memwrite,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_mdata,
  input  logic        c_halt,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [2:0]  exp_kind,
  input  logic [15:0] exp_pc,
  input  logic [3:0]  exp_reg,
  input  logic [15:0] exp_value,
  input  logic [15:0] exp_addr,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        overflow,
  output logic [15:0] inum,
  output logic [15:0] mismatch_count,
  output logic [15:0] ff_inum,
  output logic [15:0] ff_exp_pc,
  output logic [15:0] ff_got_pc
);

  state_e      state_q, state_d;
  logic        ovf_q, ovf_d;
  logic [15:0] inum_q, inum_d;
  logic [15:0] mm_q, mm_d;
  logic [15:0] ffi_q, ffi_d;
  logic [15:0] ffe_q, ffe_d;
  logic [15:0] ffg_q, ffg_d;

  rec_t cur, head, want;
  logic is_ld, is_reg, is_halt, is_st;
  logic push, xfer, full, empty;
  logic match, halt_cmp, ovf_evt;

  // Classify the current commit into one record.
  always_comb begin
    is_ld   = c_regwrite & c_memread;
    is_reg  = c_regwrite & ~c_memread;
    is_halt = ~c_regwrite & c_halt;
    is_st   = ~c_regwrite & ~c_halt & c_memwrite;
    cur     = '0;
    cur.pc  = c_pc;
    unique case (1'b1)
      is_ld: begin
        cur.kind  = KIND_LD;
        cur.rd    = c_reg;
        cur.value = c_wdata;
        cur.addr  = c_addr;
      end
      is_reg: begin
        cur.kind  = KIND_REG;
        cur.rd    = c_reg;
        cur.value = c_wdata;
      end
      is_halt: cur.kind = KIND_HALT;
      is_st: begin
        cur.kind  = KIND_ST;
        cur.value = c_mdata;
        cur.addr  = c_addr;
      end
      default: cur.kind = KIND_NOP;
    endcase
  end

  commit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (xfer),
    .din   (cur),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Handshake, compare and overflow detection.
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_PASS) || (state_q == S_FAIL);
    pass      = (state_q == S_PASS);
    fail      = (state_q == S_FAIL);
    exp_ready = busy & ~empty;
    push      = busy;
    xfer      = exp_valid & exp_ready;
    want.kind  = kind_e'(exp_kind);
    want.pc    = exp_pc;
    want.rd    = exp_reg;
    want.value = exp_value;
    want.addr  = exp_addr;
    match     = rec_match(head, want);
    halt_cmp  = (head.kind == KIND_HALT) &&
                (want.kind == KIND_HALT);
    ovf_evt   = push & full & ~xfer;
  end

  // Next-state for FSM, counters and first-fail capture.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q | ovf_evt;
    inum_d  = inum_q;
    mm_d    = mm_q;
    ffi_d   = ffi_q;
    ffe_d   = ffe_q;
    ffg_d   = ffg_q;
    if (xfer) begin
      inum_d = inum_q + 16'd1;
      if (!match) begin
        if (mm_q != 16'hFFFF) mm_d = mm_q + 16'd1;
        if (mm_q == 16'd0) begin
          ffi_d = inum_q;
          ffe_d = want.pc;
          ffg_d = head.pc;
        end
      end
    end
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (ovf_evt) begin
          state_d = S_FAIL;
        end else if (xfer) begin
          if (!match && STOP_ON_FAIL)
            state_d = S_FAIL;
          else if (halt_cmp)
            state_d = (match && mm_q == 16'd0) ?
                      S_PASS : S_FAIL;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ovf_q   <= 1'b0;
      inum_q  <= '0;
      mm_q    <= '0;
      ffi_q   <= '0;
      ffe_q   <= '0;
      ffg_q   <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      inum_q  <= inum_d;
      mm_q    <= mm_d;
      ffi_q   <= ffi_d;
      ffe_q   <= ffe_d;
      ffg_q   <= ffg_d;
    end
  end

  assign overflow       = ovf_q;
  assign inum           = inum_q;
  assign mismatch_count = mm_q;
  assign ff_inum        = ffi_q;
  assign ff_exp_pc      = ffe_q;
  assign ff_got_pc      = ffg_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Bench for commit_trace_checker: match-rule table
// plus multi-cycle sequences, scoreboard per transfer.
module tb_commit_trace_checker;
  import commit_trace_pkg::*;

  logic clk = 1'b0;
  logic rst, start;
  logic [15:0] c_pc, c_wdata, c_addr, c_mdata;
  logic [3:0]  c_reg;
  logic c_regwrite, c_memread, c_memwrite, c_halt;
  logic exp_valid;
  logic [2:0]  exp_kind;
  logic [15:0] exp_pc, exp_value, exp_addr;
  logic [3:0]  exp_reg;

  // _c: continue on mismatch, _s: stop on first mismatch
  logic rdy_c, busy_c, done_c, pass_c, fail_c, ovf_c;
  logic [15:0] inum_c, mm_c, ffi_c, ffe_c, ffg_c;
  logic rdy_s, busy_s, done_s, pass_s, fail_s, ovf_s;
  logic [15:0] inum_s, mm_s, ffi_s, ffe_s, ffg_s;

  always #5 clk = ~clk;

  commit_trace_checker #(
    .FIFO_DEPTH(4), .STOP_ON_FAIL(1'b0)
  ) u_c (
    .clk(clk), .rst(rst), .start(start),
    .c_pc(c_pc), .c_regwrite(c_regwrite), .c_reg(c_reg),
    .c_wdata(c_wdata), .c_memread(c_memread),
    .c_memwrite(c_memwrite), .c_addr(c_addr),
    .c_mdata(c_mdata), .c_halt(c_halt),
    .exp_valid(exp_valid), .exp_ready(rdy_c),
    .exp_kind(exp_kind), .exp_pc(exp_pc),
    .exp_reg(exp_reg), .exp_value(exp_value),
    .exp_addr(exp_addr),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .fail(fail_c), .overflow(ovf_c), .inum(inum_c),
    .mismatch_count(mm_c), .ff_inum(ffi_c),
    .ff_exp_pc(ffe_c), .ff_got_pc(ffg_c)
  );

  commit_trace_checker #(
    .FIFO_DEPTH(4), .STOP_ON_FAIL(1'b1)
  ) u_s (
    .clk(clk), .rst(rst), .start(start),
    .c_pc(c_pc), .c_regwrite(c_regwrite), .c_reg(c_reg),
    .c_wdata(c_wdata), .c_memread(c_memread),
    .c_memwrite(c_memwrite), .c_addr(c_addr),
    .c_mdata(c_mdata), .c_halt(c_halt),
    .exp_valid(exp_valid), .exp_ready(rdy_s),
    .exp_kind(exp_kind), .exp_pc(exp_pc),
    .exp_reg(exp_reg), .exp_value(exp_value),
    .exp_addr(exp_addr),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail(fail_s), .overflow(ovf_s), .inum(inum_s),
    .mismatch_count(mm_s), .ff_inum(ffi_s),
    .ff_exp_pc(ffe_s), .ff_got_pc(ffg_s)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] val;
    logic [15:0] addr;
  } trec_t;

  typedef struct {
    logic [15:0] inum;
    logic [15:0] mm;
  } sb_t;

  typedef struct {
    string nm;
    trec_t got;
    trec_t want;
    bit    bad;
  } vec_t;

  int total = 0;
  int bad = 0;
  int n_rec, n_mm;
  trec_t exp_q[$];
  sb_t   sb_q[$];
  vec_t  vt[$];

  function automatic trec_t mk(
    logic [2:0] k, logic [15:0] pc, logic [3:0] rg,
    logic [15:0] v, logic [15:0] a);
    trec_t r;
    r.kind = k; r.pc = pc; r.rg = rg;
    r.val = v; r.addr = a;
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] got,
                       logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic idle_commit();
    c_pc = '0; c_reg = '0; c_wdata = '0;
    c_addr = '0; c_mdata = '0;
    c_regwrite = 0; c_memread = 0;
    c_memwrite = 0; c_halt = 0;
  endtask

  // Unused commit fields get junk: they must not matter.
  task automatic drive_commit(trec_t r);
    idle_commit();
    c_pc    = r.pc;
    c_reg   = r.rg;
    c_wdata = 16'($urandom);
    c_mdata = 16'($urandom);
    c_addr  = 16'($urandom);
    case (r.kind)
      3'd1: begin c_regwrite = 1; c_wdata = r.val; end
      3'd2: begin
        c_regwrite = 1; c_memread = 1;
        c_wdata = r.val; c_addr = r.addr;
      end
      3'd3: begin
        c_memwrite = 1; c_mdata = r.val; c_addr = r.addr;
      end
      3'd4: c_halt = 1;
      default: ;
    endcase
  endtask

  task automatic commit(trec_t got, trec_t want, bit isbad);
    sb_t s;
    drive_commit(got);
    exp_q.push_back(want);
    n_rec++;
    if (isbad) n_mm++;
    s.inum = 16'(n_rec);
    s.mm   = 16'(n_mm);
    sb_q.push_back(s);
  endtask

  task automatic step(bit en);
    bit x;
    sb_t s;
    trec_t h;
    if (en && exp_q.size() > 0) begin
      h = exp_q[0];
      exp_valid = 1;
      exp_kind = h.kind; exp_pc = h.pc; exp_reg = h.rg;
      exp_value = h.val; exp_addr = h.addr;
    end else begin
      exp_valid = 0;
    end
    x = exp_valid && rdy_c;
    @(posedge clk);
    #1;
    if (x) begin
      void'(exp_q.pop_front());
      s = sb_q.pop_front();
      check("sb_inum", 32'(inum_c), 32'(s.inum));
      check("sb_mm", 32'(mm_c), 32'(s.mm));
    end
    idle_commit();
    exp_valid = 0;
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      step(1);
      n++;
    end
    if (exp_q.size() > 0)
      check("drain_timeout", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1; start = 0; exp_valid = 0;
    idle_commit();
    exp_q.delete(); sb_q.delete();
    n_rec = 0; n_mm = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Junk HALT in the start cycle must not be captured.
  task automatic start_pulse();
    start = 1;
    c_halt = 1; c_pc = 16'h7777;
    step(0);
    start = 0;
  endtask

  task automatic check_zero(string nm);
    check({nm, "_flags"},
          32'({busy_c, done_c, pass_c, fail_c, ovf_c, rdy_c,
               busy_s, done_s, pass_s, fail_s, ovf_s, rdy_s}),
          0);
    check({nm, "_cnt"}, {inum_c, mm_c}, 0);
    check({nm, "_ff"}, {ffi_c, ffe_c}, 0);
    check({nm, "_ffg"}, {ffg_c, ffg_s}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    trec_t r, w;
    rst = 1; start = 0; exp_valid = 0;
    exp_kind = '0; exp_pc = '0; exp_reg = '0;
    exp_value = '0; exp_addr = '0;
    idle_commit();

    // match-rule vectors: {name, commit, expected, mismatch}
    vt.push_back('{"reg_ok", mk(1,16'h10,1,16'h5,0),
                   mk(1,16'h10,1,16'h5,16'h99), 0});
    vt.push_back('{"reg_rd", mk(1,16'h10,1,16'h5,0),
                   mk(1,16'h10,2,16'h5,0), 1});
    vt.push_back('{"reg_val", mk(1,16'h10,1,16'h5,0),
                   mk(1,16'h10,1,16'h6,0), 1});
    vt.push_back('{"ld_ok", mk(2,16'h20,3,16'hAB,16'h40),
                   mk(2,16'h20,3,16'hAB,16'h40), 0});
    vt.push_back('{"ld_addr", mk(2,16'h20,3,16'hAB,16'h40),
                   mk(2,16'h20,3,16'hAB,16'h44), 1});
    vt.push_back('{"st_rd_dc", mk(3,16'h30,7,16'h12,16'h80),
                   mk(3,16'h30,2,16'h12,16'h80), 0});
    vt.push_back('{"st_val", mk(3,16'h30,7,16'h12,16'h80),
                   mk(3,16'h30,7,16'h13,16'h80), 1});
    vt.push_back('{"nop_dc", mk(0,16'h40,5,0,0),
                   mk(0,16'h40,9,16'hFF,16'hEE), 0});
    vt.push_back('{"nop_pc", mk(0,16'h40,0,0,0),
                   mk(0,16'h42,0,0,0), 1});
    vt.push_back('{"halt_vs_nop", mk(0,16'h50,0,0,0),
                   mk(4,16'h50,0,0,0), 1});
    vt.push_back('{"st_vs_ld", mk(3,16'h60,0,16'h1,16'h2),
                   mk(2,16'h60,0,16'h1,16'h2), 1});
    vt.push_back('{"halt_ok", mk(4,16'h70,0,0,0),
                   mk(4,16'h70,3,16'h9,16'h9), 0});

    // reset state
    do_reset();
    check_zero("reset");

    // basic passing run
    start_pulse();
    check("t1_busy", 32'(busy_c), 1);
    commit(mk(1,0,1,5,0), mk(1,0,1,5,0), 0); step(1);
    commit(mk(3,2,0,5,16'h10), mk(3,2,0,5,16'h10), 0);
    step(1);
    commit(mk(4,4,0,0,0), mk(4,4,0,0,0), 0); step(1);
    drain(10);
    check("t1_pass", 32'({pass_c, pass_s, done_c, busy_c}),
          32'b1110);
    check("t1_inum", 32'(inum_c), 3);
    check("t1_mm", 32'(mm_s), 0);

    // stop on first mismatch
    do_reset();
    start_pulse();
    commit(mk(1,0,1,5,0), mk(1,0,1,6,0), 1); step(1);
    commit(mk(3,2,0,5,16'h10), mk(3,2,0,5,16'h10), 0);
    step(1);
    check("t2_fail_s", 32'({fail_s, mm_s}), 32'h1_0001);
    commit(mk(4,4,0,0,0), mk(4,4,0,0,0), 0); step(1);
    drain(10);
    check("t2_ff_s", {ffi_s, ffe_s}, 0);
    check("t2_ffg_s", 32'(ffg_s), 0);
    check("t2_inum_s", 32'(inum_s), 1);
    check("t2_c_end", 32'({fail_c, pass_c, inum_c}),
          32'h2_0003);

    // continue past mismatch to HALT
    do_reset();
    start_pulse();
    commit(mk(1,0,2,16'h11,0), mk(1,0,2,16'h11,0), 0);
    step(1);
    commit(mk(3,2,0,16'h11,16'h20),
           mk(3,2,0,16'h11,16'h20), 0);
    step(1);
    commit(mk(2,4,3,16'h33,16'h20),
           mk(2,4,3,16'h33,16'h24), 1);
    step(1);
    commit(mk(0,6,0,0,0), mk(0,6,0,0,0), 0); step(1);
    commit(mk(4,8,0,0,0), mk(4,8,0,0,0), 0); step(1);
    drain(10);
    check("t3_state", 32'({fail_c, pass_c}), 32'b10);
    check("t3_mm", 32'(mm_c), 1);
    check("t3_ff", {ffi_c, ffe_c}, 32'h0002_0004);
    check("t3_ffg", 32'(ffg_c), 4);
    check("t3_inum", 32'(inum_c), 5);
    check("t3_s", 32'({fail_s, inum_s, ffi_s}),
          32'(49'h1_0003_0002));

    // overflow with expected stream stalled
    do_reset();
    start_pulse();
    for (int i = 0; i < 6; i++) begin
      r = mk(1, 16'(2*i), 4'(i), 16'(i), 0);
      commit(r, r, 0);
      step(0);
      if (i == 3)
        check("t4_pre", 32'({ovf_c, fail_c, rdy_c}),
              32'b001);
      if (i == 4)
        check("t4_ovf", 32'({ovf_c, fail_c, rdy_c, ovf_s}),
              32'b1101);
    end
    check("t4_end", 32'({ovf_c, fail_c, busy_c}), 32'b110);

    // toggling stream, full with push and pop together
    do_reset();
    start_pulse();
    for (int j = 1; j <= 12; j++) begin
      if (j == 12) r = mk(4, 16'(2*j), 0, 0, 0);
      else if (j % 2 == 1)
        r = mk(1, 16'(2*j), 4'(j), 16'(3*j), 0);
      else r = mk(0, 16'(2*j), 0, 0, 0);
      commit(r, r, 0);
      step((j > 8) || (j % 2 == 0));
    end
    drain(20);
    check("t5_ovf", 32'({ovf_c, ovf_s}), 0);
    check("t5_pass", 32'({pass_c, pass_s}), 32'b11);
    check("t5_inum", 32'(inum_c), 12);

    // async reset mid-run, then a one-record run
    do_reset();
    start_pulse();
    r = mk(1,0,1,1,0); commit(r, r, 0); step(1);
    r = mk(1,2,1,2,0); commit(r, r, 0); step(1);
    r = mk(1,4,1,3,0); commit(r, r, 0); step(1);
    check("t6_pre", 32'(inum_c), 2);
    rst = 1;
    #1;
    check_zero("t6_rst");
    do_reset();
    start_pulse();
    r = mk(4,16'h40,0,0,0); commit(r, r, 0); step(1);
    drain(10);
    check("t6_pass", 32'({pass_c, pass_s}), 32'b11);
    check("t6_inum", 32'(inum_c), 1);

    // match-rule table
    foreach (vt[k]) begin
      do_reset();
      start_pulse();
      commit(vt[k].got, vt[k].want, vt[k].bad);
      step(1);
      drain(5);
      check(vt[k].nm, 32'(mm_c), 32'(vt[k].bad));
      check({vt[k].nm, "_s"}, 32'(fail_s), 32'(vt[k].bad));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
